// File: rtl/iter_divider_if.sv
// Execution-stage <-> divider connection: start request, operands, abort,
// and the quotient/remainder write-back returned by the divider.
interface iter_divider_if #(
   parameter int XLEN = 32
);
   logic [2:0]      div_inst;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            flush;
   logic            busy;
   logic            div_wb;
   logic [XLEN-1:0] Qo;
   logic [XLEN-1:0] Ro;
   logic            RSIGN;

   modport master (
      output div_inst, rs1_data, rs2_data, flush,
      input  busy, div_wb, Qo, Ro, RSIGN
   );

   modport slave (
      input  div_inst, rs1_data, rs2_data, flush,
      output busy, div_wb, Qo, Ro, RSIGN
   );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Magnitudes are divided unsigned; signs are re-applied in a single fix-up cycle.
module iter_divider #(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          reset,
   iter_divider_if.slave dif
);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] dvd_reg, dvd_next;
   logic [XLEN-1:0] dvs_reg, dvs_next;
   logic [XLEN-1:0] rem_reg, rem_next;
   logic [XLEN-1:0] qo_reg, qo_next;
   logic [XLEN-1:0] ro_reg, ro_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic            q_neg_reg, q_neg_next;
   logic            r_neg_reg, r_neg_next;
   logic            rsign_reg, rsign_next;

   logic            start;
   logic            is_signed;
   logic            sign_a, sign_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero;
   logic            overflow;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] fix_q, fix_r;

   // A request with both bit0 and bit1 set is still treated as signed.
   assign start     = |dif.div_inst;
   assign is_signed = dif.div_inst[0];
   assign sign_a    = is_signed & dif.rs1_data[XLEN-1];
   assign sign_b    = is_signed & dif.rs2_data[XLEN-1];
   assign mag_a     = sign_a ? -dif.rs1_data : dif.rs1_data;
   assign mag_b     = sign_b ? -dif.rs2_data : dif.rs2_data;
   assign div_zero  = (dif.rs2_data == '0);
   assign overflow  = is_signed
                   && (dif.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (dif.rs2_data == '1);

   // Partial remainder < divisor, so bit XLEN of trial is a clean borrow flag.
   assign shifted = {rem_reg, dvd_reg[XLEN-1]};
   assign trial   = shifted - {1'b0, dvs_reg};

   // The dividend register doubles as the quotient accumulator.
   assign fix_q = q_neg_reg ? -dvd_reg : dvd_reg;
   assign fix_r = r_neg_reg ? -rem_reg : rem_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         dvd_reg   <= '0;
         dvs_reg   <= '0;
         rem_reg   <= '0;
         cnt_reg   <= '0;
         q_neg_reg <= 1'b0;
         r_neg_reg <= 1'b0;
         qo_reg    <= '0;
         ro_reg    <= '0;
         rsign_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         dvd_reg   <= dvd_next;
         dvs_reg   <= dvs_next;
         rem_reg   <= rem_next;
         cnt_reg   <= cnt_next;
         q_neg_reg <= q_neg_next;
         r_neg_reg <= r_neg_next;
         qo_reg    <= qo_next;
         ro_reg    <= ro_next;
         rsign_reg <= rsign_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      dvd_next   = dvd_reg;
      dvs_next   = dvs_reg;
      rem_next   = rem_reg;
      cnt_next   = cnt_reg;
      q_neg_next = q_neg_reg;
      r_neg_next = r_neg_reg;
      qo_next    = qo_reg;
      ro_next    = ro_reg;
      rsign_next = rsign_reg;

      // Abort leaves the visible results untouched.
      if (dif.flush) begin
         state_next = IDLE;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (start) begin
                  dvd_next   = mag_a;
                  dvs_next   = mag_b;
                  rem_next   = '0;
                  cnt_next   = CNT_W'(XLEN - 1);
                  q_neg_next = sign_a ^ sign_b;
                  r_neg_next = sign_a;
                  if (div_zero) begin
                     qo_next    = '1;
                     ro_next    = dif.rs1_data;
                     rsign_next = dif.rs1_data[XLEN-1];
                     state_next = DONE;
                  end else if (overflow) begin
                     qo_next    = {1'b1, {(XLEN-1){1'b0}}};
                     ro_next    = '0;
                     rsign_next = 1'b0;
                     state_next = DONE;
                  end else begin
                     state_next = CALC;
                  end
               end
            end
            CALC: begin
               dvd_next = {dvd_reg[XLEN-2:0], ~trial[XLEN]};
               rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
               if (cnt_reg == '0) begin
                  state_next = FIX;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
            FIX: begin
               qo_next    = fix_q;
               ro_next    = fix_r;
               rsign_next = fix_r[XLEN-1];
               state_next = DONE;
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign dif.busy   = (state_reg != IDLE);
   assign dif.div_wb = (state_reg == DONE);
   assign dif.Qo     = qo_reg;
   assign dif.Ro     = ro_reg;
   assign dif.RSIGN  = rsign_reg;
endmodule
